// File: rtl/act_pkg.sv
// Shared activation format definitions and the fixed-point rescale helper
// used by the feeder and by any other layer consuming 8-bit activations.
package act_pkg;

    localparam int ACT_W     = 9;
    localparam int ACT_MAG_W = 8;
    localparam int DEQ_W     = 64;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Places the magnitude at bits slice-1:slice-8; callers truncate to out_w.
    function automatic logic [DEQ_W-1:0] act_dequant(
        input logic [ACT_MAG_W-1:0] mag,
        input int                   slice,
        input int                   out_w
    );
        logic [DEQ_W-1:0] val;
        logic [DEQ_W-1:0] mask;
        val  = {{(DEQ_W-ACT_MAG_W){1'b0}}, mag} << (slice - ACT_MAG_W);
        mask = ~({DEQ_W{1'b1}} << out_w);
        return val & mask;
    endfunction

endpackage

// File: rtl/relu_act_feeder_if.sv
// Vector-in / element-out handshake bundle for the activation feeder.
interface relu_act_feeder_if
    import act_pkg::*;
#(
    parameter int ROWS  = 64,
    parameter int OUT_W = 26,
    parameter int IDX_W = $clog2(ROWS)
);
    logic                    in_valid;
    logic                    in_ready;
    logic [ACT_W-1:0]        in_data [0:ROWS-1];
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic [IDX_W-1:0]        out_index;
    logic                    out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/relu_act_feeder.sv
// Captures a ROWS-wide activation vector and streams one rescaled element per cycle; 1-cycle capture-to-output latency.
// Backpressure: element held while out_ready low; next vector accepted only in IDLE or on the last element's transfer.
module relu_act_feeder
    import act_pkg::*;
#(
    parameter int ROWS  = 64,
    parameter int SLICE = 21,
    parameter int OUT_W = 26,
    parameter int IDX_W = $clog2(ROWS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    relu_act_feeder_if.slave     bus,
    output logic                 busy,
    output logic                 err_fmt
);

    generate
        if (SLICE > OUT_W - 1 || SLICE < ACT_MAG_W) begin : g_bad_slice
            $error("relu_act_feeder: SLICE must satisfy 8 <= SLICE <= OUT_W-1");
        end
    endgenerate

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [ACT_W-1:0] act_buf [0:ROWS-1];
    logic             capture;
    logic             xfer;
    logic             last;
    logic             fmt_bad;

    assign last    = (state == STREAM) && (idx == IDX_W'(ROWS - 1));
    assign xfer    = (state == STREAM) && bus.out_ready;
    assign capture = bus.in_valid && bus.in_ready;

    // Same-cycle refill on the last transfer keeps the stream bubble-free.
    assign bus.in_ready  = (state == IDLE) || (xfer && last);
    assign bus.out_valid = (state == STREAM);
    assign bus.out_index = idx;
    assign bus.out_last  = last;
    assign bus.out_data  = (state == STREAM)
                         ? OUT_W'(act_dequant(act_buf[idx][ACT_MAG_W-1:0], SLICE, OUT_W))
                         : '0;
    assign busy          = (state == STREAM);

    always_comb begin
        fmt_bad = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            fmt_bad = fmt_bad | bus.in_data[i][ACT_W-1];
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (capture) begin
            state_nxt = STREAM;
            idx_nxt   = '0;
        end else if (xfer) begin
            if (last) begin
                state_nxt = IDLE;
            end else begin
                idx_nxt = idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            err_fmt <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (capture && fmt_bad) begin
                err_fmt <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            act_buf <= bus.in_data;
        end
    end

endmodule

// File: tb/tb_relu_act_feeder.sv
// Scoreboard bench for relu_act_feeder: expected elements queued on capture, compared on transfer.
module tb_relu_act_feeder;
    import act_pkg::*;

    localparam int ROWS  = 64;
    localparam int SLICE = 21;
    localparam int OUT_W = 26;
    localparam int IDX_W = 6;

    typedef logic [8:0] vec_t [0:ROWS-1];
    typedef struct packed {
        logic [OUT_W-1:0] dat;
        logic [IDX_W-1:0] idx;
        logic             last;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic err_fmt;

    relu_act_feeder_if #(.ROWS(ROWS), .OUT_W(OUT_W), .IDX_W(IDX_W)) bus ();

    relu_act_feeder #(.ROWS(ROWS), .SLICE(SLICE), .OUT_W(OUT_W), .IDX_W(IDX_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .err_fmt (err_fmt)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb[$];
    logic stall_p  = 1'b0;
    exp_t stall_v;
    logic cap_p    = 1'b0;
    int   cap_cyc  = 0;
    int   last_span = 0;
    bit   tog_en   = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready: held high normally, alternates 1010... when tog_en is set.
    always @(posedge clk) begin
        #1;
        bus.out_ready = tog_en ? ~bus.out_ready : 1'b1;
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb.delete();
            stall_p = 1'b0;
            cap_p   = 1'b0;
        end else begin
            exp_t cur;
            exp_t e;
            cur = {bus.out_data, bus.out_index, bus.out_last};
            if (cap_p) begin
                check("first_valid", {63'd0, bus.out_valid}, 64'd1);
                check("first_index", {58'd0, bus.out_index}, 64'd0);
            end
            if (stall_p) check("stall_hold", {31'd0, cur}, {31'd0, stall_v});
            check("busy_vs_valid", {63'd0, busy}, {63'd0, bus.out_valid});
            check("in_ready", {63'd0, bus.in_ready},
                  {63'd0, (!bus.out_valid || (bus.out_ready && bus.out_last))});
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_data",  {38'd0, bus.out_data},  {38'd0, e.dat});
                    check("out_index", {58'd0, bus.out_index}, {58'd0, e.idx});
                    check("out_last",  {63'd0, bus.out_last},  {63'd0, e.last});
                end
                if (bus.out_last) last_span = cyc - cap_cyc;
            end
            stall_p = bus.out_valid && !bus.out_ready;
            stall_v = cur;
            cap_p   = bus.in_valid && bus.in_ready;
            if (cap_p) begin
                cap_cyc = cyc;
                for (int i = 0; i < ROWS; i++) begin
                    e.dat  = OUT_W'({18'd0, bus.in_data[i][7:0]} << (SLICE - 8));
                    e.idx  = IDX_W'(i);
                    e.last = (i == ROWS - 1);
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic send(input vec_t v, input bit hold);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        @(negedge clk);
        while (!bus.in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.in_valid = 1'b0;
            for (int i = 0; i < ROWS; i++) bus.in_data[i] = 9'($urandom);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("drain_timeout", 64'd1, 64'd0);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < ROWS; i++) v[i] = {1'b0, 8'($urandom)};
        return v;
    endfunction

    initial begin
        vec_t v;
        vec_t a;
        vec_t b;
        int   n;
        bus.in_valid = 1'b0;
        for (int i = 0; i < ROWS; i++) bus.in_data[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_busy",      {63'd0, busy},          64'd0);
        check("rst_err_fmt",   {63'd0, err_fmt},       64'd0);
        check("rst_out_data",  {38'd0, bus.out_data},  64'd0);
        check("rst_out_last",  {63'd0, bus.out_last},  64'd0);
        check("rst_out_index", {58'd0, bus.out_index}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", {63'd0, bus.in_ready}, 64'd1);

        // Basic vector with full-scale and unit magnitudes.
        for (int i = 0; i < ROWS; i++) v[i] = '0;
        v[0] = 9'h0FF;
        v[1] = 9'h001;
        send(v, 1'b0);
        wait_drain();
        check("vector_span", 64'(last_span), 64'd64);
        check("err_fmt_clean", {63'd0, err_fmt}, 64'd0);

        // Stalled stream with alternating out_ready.
        tog_en = 1'b1;
        send(rand_vec(), 1'b0);
        wait_drain();
        tog_en = 1'b0;
        @(negedge clk);

        // Back-to-back vectors with in_valid held.
        a = rand_vec();
        b = rand_vec();
        send(a, 1'b1);
        send(b, 1'b0);
        wait_drain();
        check("err_fmt_still_clean", {63'd0, err_fmt}, 64'd0);

        // Reserved bit set: magnitude still used, sticky error raised.
        for (int i = 0; i < ROWS; i++) v[i] = '0;
        v[5] = 9'h180;
        v[7] = 9'h03C;
        send(v, 1'b0);
        check("err_fmt_rise", {63'd0, err_fmt}, 64'd1);
        wait_drain();
        check("err_fmt_sticky", {63'd0, err_fmt}, 64'd1);

        // Asynchronous reset in the middle of a vector.
        send(rand_vec(), 1'b0);
        n = 0;
        while (!(bus.out_valid && bus.out_index == IDX_W'(30)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idx30_timeout", 64'd1, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("arst_out_data",  {38'd0, bus.out_data},  64'd0);
        check("arst_out_index", {58'd0, bus.out_index}, 64'd0);
        check("arst_out_last",  {63'd0, bus.out_last},  64'd0);
        check("arst_busy",      {63'd0, busy},          64'd0);
        check("arst_err_fmt",   {63'd0, err_fmt},       64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_arst", {63'd0, bus.in_ready}, 64'd1);
        send(rand_vec(), 1'b0);
        wait_drain();
        check("post_rst_span", 64'(last_span), 64'd64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
